// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared constants and the token-width helper for rr_arbiter.
package rr_arbiter_pkg;
   localparam int RR_DEFAULT_N = 4;
   function automatic int rr_tok_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter_prio_enc.sv
// rr_arbiter_prio_enc: grants the first set req bit searching upward from token with wrap-around.
module rr_arbiter_prio_enc
   import rr_arbiter_pkg::*;
#(
   parameter int N = RR_DEFAULT_N,
   localparam int W = rr_tok_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] token,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);
   function automatic logic [W-1:0] rot_idx(input logic [W-1:0] t, input int k);
      return W'((int'(t) + k) % N);
   endfunction
   // Scan from the farthest offset down so the nearest requester overwrites the result.
   always_comb begin
      gnt = '0;
      gnt_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[rot_idx(token, k)]) begin
            gnt = '0;
            gnt[rot_idx(token, k)] = 1'b1;
            gnt_idx = rot_idx(token, k);
         end
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with rotating priority token.
// Define RR_ARBITER_GNT_REG_EN to register gnt (one-cycle latency); default is combinational.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N = RR_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int W = rr_tok_w(N);
   logic [W-1:0] pr_token_cntr, pr_token_cntr_d, gnt_idx;
   logic [N-1:0] gnt_c;
   rr_arbiter_prio_enc #(.N(N)) u_prio_enc (
      .req     (req),
      .token   (pr_token_cntr),
      .gnt     (gnt_c),
      .gnt_idx (gnt_idx)
   );
   // Explicit wrap keeps the token below N for non-power-of-2 sizes.
   always_comb
      pr_token_cntr_d = rstn ? '0
                      : !(|gnt_c) ? pr_token_cntr
                      : (gnt_idx == W'(N - 1)) ? '0
                      : gnt_idx + 1'b1;
   always_ff @(posedge clk)
      pr_token_cntr <= pr_token_cntr_d;
`ifdef RR_ARBITER_GNT_REG_EN
   logic [N-1:0] gnt_q, gnt_d;
   always_comb gnt_d = rstn ? '0 : gnt_c;
   always_ff @(posedge clk)
      gnt_q <= gnt_d;
   assign gnt = rstn ? '0 : gnt_q;
`else
   assign gnt = rstn ? '0 : gnt_c;
`endif
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and randomized checks of rr_arbiter (N=4) against a rotation model.
module tb_rr_arbiter;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   int tests = 0;
   int fails = 0;
   int tm = 0;
   logic [N-1:0] last_gnt;
   logic [N-1:0] fl_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   rr_arbiter #(.N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .req  (req),
      .gnt  (gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs, check the grant mid-cycle, then the token after the edge.
   task automatic step(input logic r, input logic [N-1:0] q);
      int eg;
      eg = -1;
      rstn = r;
      req = q;
      @(negedge clk);
      if (!r)
         for (int k = 0; k < N; k++)
            if (eg < 0 && q[(tm + k) % N]) eg = (tm + k) % N;
      last_gnt = gnt;
      chk("gnt", 32'(gnt), (eg < 0) ? 32'd0 : 32'd1 << eg);
      chk("gnt_in_req", 32'(gnt & ~q), 32'd0);
      tm = r ? 0 : (eg < 0) ? tm : (eg + 1) % N;
      @(posedge clk);
      #1;
      chk("token", 32'(dut.pr_token_cntr), 32'(tm));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      step(1'b1, 4'b1111);
      chk("rst_gnt", 32'(last_gnt), 32'd0);
      chk("rst_tok", 32'(dut.pr_token_cntr), 32'd0);
      step(1'b0, 4'b0010);
      chk("best_gnt", 32'(last_gnt), 32'b0010);
      chk("best_tok", 32'(dut.pr_token_cntr), 32'd2);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'b0100);
         chk("hold_gnt", 32'(last_gnt), 32'b0100);
      end
      chk("hold_tok", 32'(dut.pr_token_cntr), 32'd3);
      step(1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b1111);
         chk("full_gnt", 32'(last_gnt), 32'(fl_exp[i]));
      end
      step(1'b0, 4'b0100);
      chk("pre_wrap_tok", 32'(dut.pr_token_cntr), 32'd3);
      step(1'b0, 4'b0001);
      chk("wrap_gnt", 32'(last_gnt), 32'b0001);
      chk("wrap_tok", 32'(dut.pr_token_cntr), 32'd1);
      step(1'b0, 4'b0000);
      chk("idle_gnt", 32'(last_gnt), 32'd0);
      chk("idle_tok", 32'(dut.pr_token_cntr), 32'd1);
      step(1'b0, 4'b0010);
      chk("pre_rst_tok", 32'(dut.pr_token_cntr), 32'd2);
      step(1'b1, 4'b1111);
      chk("mid_rst_gnt", 32'(last_gnt), 32'd0);
      chk("mid_rst_tok", 32'(dut.pr_token_cntr), 32'd0);
      step(1'b0, 4'b1111);
      chk("post_rst_gnt", 32'(last_gnt), 32'b0001);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 19) == 0, N'($urandom));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
